// File: rtl/cache_controller_if.sv
// Bundles the CPU, valid-store, RAM and statistics signals of the cache controller.
// The master modport is the controller's view; slave is the surrounding system.
interface cache_controller_if;
  logic        cpuReq;
  logic        cpuWrEn;
  logic [15:0] cpuAddr;
  logic [31:0] cpuWrData;
  logic        cpuReady;
  logic        cpuDone;
  logic [31:0] cpuRdData;
  logic [9:0]  vAddress;
  logic        vWrEn;
  logic        vInValidity;
  logic        vIsValid;
  logic        ramReq;
  logic        ramWrEn;
  logic [15:0] ramAddr;
  logic [31:0] ramWrData;
  logic [31:0] ramRdData;
  logic        ramAck;
  logic [15:0] hitCount;
  logic [15:0] missCount;

  modport master (
    input  cpuReq, cpuWrEn, cpuAddr, cpuWrData, vIsValid, ramRdData, ramAck,
    output cpuReady, cpuDone, cpuRdData, vAddress, vWrEn, vInValidity,
           ramReq, ramWrEn, ramAddr, ramWrData, hitCount, missCount
  );

  modport slave (
    output cpuReq, cpuWrEn, cpuAddr, cpuWrData, vIsValid, ramRdData, ramAck,
    input  cpuReady, cpuDone, cpuRdData, vAddress, vWrEn, vInValidity,
           ramReq, ramWrEn, ramAddr, ramWrData, hitCount, missCount
  );
endinterface

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller: 1024 one-word
// lines with internal tag/data arrays and valid bits kept in an external store.
module cache_controller (
  input  logic               globalclock,
  input  logic               reset,
  cache_controller_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, LOOKUP = 2'd1, REFILL = 2'd2, WTHRU = 2'd3} state_t;

  state_t      state_r;
  logic [5:0]  tag_array  [1024];
  logic [31:0] data_array [1024];
  logic [15:0] addr_r;
  logic        wr_en_r;
  logic [31:0] wr_data_r;
  logic        ready_r;
  logic        done_r;
  logic [31:0] rd_data_r;
  logic        ram_req_r;
  logic        ram_wr_en_r;
  logic [15:0] ram_addr_r;
  logic [31:0] ram_wr_data_r;
  logic [15:0] hit_count_r;
  logic [15:0] miss_count_r;
  logic [9:0]  index_s;
  logic [5:0]  tag_s;
  logic        hit_s;
  logic        fill_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign index_s = addr_r[9:0];
  assign tag_s   = addr_r[15:10];
  assign hit_s   = bus.vIsValid && (tag_array[index_s] == tag_s);
  // A refill completes only on an un-reset ack cycle, so reset can never set a valid bit.
  assign fill_s  = (state_r == REFILL) && bus.ramAck && !reset;

  assign bus.cpuReady    = ready_r;
  assign bus.cpuDone     = done_r;
  assign bus.cpuRdData   = rd_data_r;
  assign bus.vAddress    = index_s;
  assign bus.vWrEn       = fill_s;
  assign bus.vInValidity = 1'b1;
  assign bus.ramReq      = ram_req_r;
  assign bus.ramWrEn     = ram_wr_en_r;
  assign bus.ramAddr     = ram_addr_r;
  assign bus.ramWrData   = ram_wr_data_r;
  assign bus.hitCount    = hit_count_r;
  assign bus.missCount   = miss_count_r;

  // Tag/data array updates: line fill on refill ack, write-hit update in LOOKUP.
  always_ff @(posedge globalclock) begin
    if (fill_s) begin
      tag_array[index_s]  <= tag_s;
      data_array[index_s] <= bus.ramRdData;
    end else if (!reset && (state_r == LOOKUP) && wr_en_r && hit_s) begin
      data_array[index_s] <= wr_data_r;
    end
  end

  // Controller FSM with registered CPU/RAM outputs and saturating statistics.
  always_ff @(posedge globalclock) begin
    if (reset) begin
      state_r       <= IDLE;
      ready_r       <= 1'b1;
      done_r        <= 1'b0;
      rd_data_r     <= 32'd0;
      ram_req_r     <= 1'b0;
      ram_wr_en_r   <= 1'b0;
      ram_addr_r    <= 16'd0;
      ram_wr_data_r <= 32'd0;
      hit_count_r   <= 16'd0;
      miss_count_r  <= 16'd0;
      addr_r        <= 16'd0;
      wr_en_r       <= 1'b0;
      wr_data_r     <= 32'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.cpuReq) begin
            addr_r    <= bus.cpuAddr;
            wr_en_r   <= bus.cpuWrEn;
            wr_data_r <= bus.cpuWrData;
            ready_r   <= 1'b0;
            state_r   <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (wr_en_r) begin
            if (hit_s) begin
              hit_count_r <= sat_inc(hit_count_r);
            end
            ram_req_r     <= 1'b1;
            ram_wr_en_r   <= 1'b1;
            ram_addr_r    <= addr_r;
            ram_wr_data_r <= wr_data_r;
            state_r       <= WTHRU;
          end else if (hit_s) begin
            rd_data_r   <= data_array[index_s];
            done_r      <= 1'b1;
            hit_count_r <= sat_inc(hit_count_r);
            ready_r     <= 1'b1;
            state_r     <= IDLE;
          end else begin
            miss_count_r <= sat_inc(miss_count_r);
            ram_req_r    <= 1'b1;
            ram_wr_en_r  <= 1'b0;
            ram_addr_r   <= addr_r;
            state_r      <= REFILL;
          end
        end
        REFILL: begin
          if (bus.ramAck) begin
            rd_data_r <= bus.ramRdData;
            done_r    <= 1'b1;
            ram_req_r <= 1'b0;
            ready_r   <= 1'b1;
            state_r   <= IDLE;
          end
        end
        WTHRU: begin
          if (bus.ramAck) begin
            done_r      <= 1'b1;
            ram_req_r   <= 1'b0;
            ram_wr_en_r <= 1'b0;
            ready_r     <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          ram_req_r <= 1'b0;
          ready_r   <= 1'b1;
          state_r   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: directed scenarios plus randomized traffic checked
// against an abstract direct-mapped cache model and a word-addressed RAM model.
module tb_cache_controller;
  logic globalclock;
  logic reset;
  cache_controller_if cif ();

  cache_controller dut (
    .globalclock (globalclock),
    .reset       (reset),
    .bus         (cif)
  );

  initial globalclock = 1'b0;
  always #5 globalclock = ~globalclock;

  // External valid-bit store, cleared by the shared reset.
  logic valid_store [1024];
  always_ff @(posedge globalclock) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) valid_store[i] <= 1'b0;
    end else if (cif.vWrEn) begin
      valid_store[cif.vAddress] <= cif.vInValidity;
    end
  end
  assign cif.vIsValid = valid_store[cif.vAddress];

  int vectors = 0;
  int miscompares = 0;

  // Reference model: what the cache should hold, plus the RAM's contents.
  bit          ref_valid [1024];
  logic [5:0]  ref_tag   [1024];
  logic [31:0] ref_data  [1024];
  logic [15:0] ref_hits;
  logic [15:0] ref_misses;
  logic [31:0] ram_mem [logic [15:0]];

  function automatic logic [31:0] ram_word(input logic [15:0] a);
    if (ram_mem.exists(a)) return ram_mem[a];
    return {a, ~a};
  endfunction

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? 16'hFFFF : v + 16'd1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) ref_valid[i] = 1'b0;
    ref_hits   = 16'd0;
    ref_misses = 16'd0;
  endtask

  // One CPU transaction, issued at a negedge; returns at the negedge after cpuDone.
  task automatic txn(input bit we, input logic [15:0] a, input logic [31:0] wd,
                     input int dly, input bit spur);
    logic [9:0]  idx;
    logic [5:0]  tg;
    logic [31:0] exp_rd;
    bit          exp_hit;
    idx     = a[9:0];
    tg      = a[15:10];
    exp_hit = ref_valid[idx] && (ref_tag[idx] == tg);
    check("ready_idle", {31'd0, cif.cpuReady}, 32'd1);
    cif.cpuReq    = 1'b1;
    cif.cpuWrEn   = we;
    cif.cpuAddr   = a;
    cif.cpuWrData = wd;
    cif.ramAck    = spur;
    @(negedge globalclock);
    cif.cpuReq    = 1'b0;
    cif.cpuAddr   = 16'($urandom);
    check("ready_busy", {31'd0, cif.cpuReady}, 32'd0);
    check("done_early", {31'd0, cif.cpuDone}, 32'd0);
    check("vaddress", {22'd0, cif.vAddress}, {22'd0, idx});
    @(negedge globalclock);
    cif.ramAck = 1'b0;
    if (!we && exp_hit) begin
      ref_hits = sat16(ref_hits);
      check("hit_done", {31'd0, cif.cpuDone}, 32'd1);
      check("hit_data", cif.cpuRdData, ref_data[idx]);
      check("hit_noreq", {31'd0, cif.ramReq}, 32'd0);
    end else begin
      check("ram_req", {31'd0, cif.ramReq}, 32'd1);
      check("ram_wren", {31'd0, cif.ramWrEn}, {31'd0, we});
      check("ram_addr", {16'd0, cif.ramAddr}, {16'd0, a});
      check("miss_nodone", {31'd0, cif.cpuDone}, 32'd0);
      if (we) check("ram_wdata", cif.ramWrData, wd);
      if (we && exp_hit) begin
        ref_data[idx] = wd;
        ref_hits      = sat16(ref_hits);
      end
      if (!we) ref_misses = sat16(ref_misses);
      for (int i = 0; i < dly; i++) begin
        @(negedge globalclock);
        check("req_hold", {31'd0, cif.ramReq}, 32'd1);
        check("vwren_wait", {31'd0, cif.vWrEn}, 32'd0);
      end
      exp_rd        = ram_word(a);
      cif.ramRdData = exp_rd;
      cif.ramAck    = 1'b1;
      #1;
      check("vwren_ack", {31'd0, cif.vWrEn}, {31'd0, !we});
      @(negedge globalclock);
      cif.ramAck    = 1'b0;
      cif.ramRdData = $urandom;
      check("ack_done", {31'd0, cif.cpuDone}, 32'd1);
      check("req_drop", {31'd0, cif.ramReq}, 32'd0);
      check("vwren_after", {31'd0, cif.vWrEn}, 32'd0);
      if (we) begin
        ram_mem[a] = wd;
      end else begin
        check("fill_data", cif.cpuRdData, exp_rd);
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = tg;
        ref_data[idx]  = exp_rd;
      end
    end
    check("hit_count", {16'd0, cif.hitCount}, {16'd0, ref_hits});
    check("miss_count", {16'd0, cif.missCount}, {16'd0, ref_misses});
  endtask

  initial begin
    logic [15:0] ra;
    cif.cpuReq    = 1'b0;
    cif.cpuWrEn   = 1'b0;
    cif.cpuAddr   = 16'd0;
    cif.cpuWrData = 32'd0;
    cif.ramRdData = 32'd0;
    cif.ramAck    = 1'b0;
    reset         = 1'b1;
    model_reset();
    ram_mem[16'h0405] = 32'hDEADBEEF;
    ram_mem[16'h0805] = 32'hCAFEF00D;
    repeat (3) @(negedge globalclock);
    reset = 1'b0;
    check("rst_ready", {31'd0, cif.cpuReady}, 32'd1);
    check("rst_done", {31'd0, cif.cpuDone}, 32'd0);
    check("rst_rdata", cif.cpuRdData, 32'd0);
    check("rst_req", {31'd0, cif.ramReq}, 32'd0);
    check("rst_wren", {31'd0, cif.ramWrEn}, 32'd0);
    check("rst_raddr", {16'd0, cif.ramAddr}, 32'd0);
    check("rst_wdata", cif.ramWrData, 32'd0);
    check("rst_vwren", {31'd0, cif.vWrEn}, 32'd0);
    check("rst_hits", {16'd0, cif.hitCount}, 32'd0);
    check("rst_misses", {16'd0, cif.missCount}, 32'd0);

    // Miss, hit, conflict eviction, write hit and write miss, back to back.
    txn(1'b0, 16'h0405, 32'd0, 2, 1'b0);
    check("first_fill", cif.cpuRdData, 32'hDEADBEEF);
    txn(1'b0, 16'h0405, 32'd0, 0, 1'b1);
    check("rehit_data", cif.cpuRdData, 32'hDEADBEEF);
    txn(1'b0, 16'h0805, 32'd0, 1, 1'b0);
    txn(1'b0, 16'h0405, 32'd0, 0, 1'b0);
    txn(1'b1, 16'h0405, 32'h12345678, 3, 1'b1);
    txn(1'b0, 16'h0405, 32'd0, 0, 1'b0);
    check("wr_hit_data", cif.cpuRdData, 32'h12345678);
    txn(1'b1, 16'h0C07, 32'hA5A5_0F0F, 1, 1'b0);
    txn(1'b0, 16'h0C07, 32'd0, 0, 1'b0);
    check("wr_miss_read", cif.cpuRdData, 32'hA5A5_0F0F);

    // Reset two cycles into a refill, ack arriving afterwards.
    cif.cpuReq  = 1'b1;
    cif.cpuWrEn = 1'b0;
    cif.cpuAddr = 16'h1123;
    @(negedge globalclock);
    cif.cpuReq = 1'b0;
    @(negedge globalclock);
    check("rr_req", {31'd0, cif.ramReq}, 32'd1);
    repeat (2) @(negedge globalclock);
    reset = 1'b1;
    model_reset();
    @(negedge globalclock);
    check("rr_req_drop", {31'd0, cif.ramReq}, 32'd0);
    check("rr_nodone", {31'd0, cif.cpuDone}, 32'd0);
    cif.ramRdData = 32'h0BAD_0BAD;
    cif.ramAck    = 1'b1;
    #1;
    check("rr_vwren", {31'd0, cif.vWrEn}, 32'd0);
    @(negedge globalclock);
    cif.ramAck = 1'b0;
    reset      = 1'b0;
    check("rr_nodone2", {31'd0, cif.cpuDone}, 32'd0);
    @(negedge globalclock);
    check("rr_nodone3", {31'd0, cif.cpuDone}, 32'd0);
    check("rr_req_idle", {31'd0, cif.ramReq}, 32'd0);
    check("rr_hits", {16'd0, cif.hitCount}, 32'd0);
    check("rr_misses", {16'd0, cif.missCount}, 32'd0);
    check("rr_valid", {31'd0, valid_store[10'h123]}, 32'd0);

    // Randomized traffic over a small address pool so hits and conflicts both occur.
    for (int n = 0; n < 120; n++) begin
      ra = {6'($urandom_range(0, 3)), 10'($urandom_range(0, 7))};
      txn(($urandom_range(0, 2) == 0), ra, $urandom, $urandom_range(0, 3),
          ($urandom_range(0, 4) == 0));
    end

    // Hit counter saturation.
    txn(1'b0, 16'h0405, 32'd0, 0, 1'b0);
    force dut.hit_count_r = 16'hFFFE;
    @(negedge globalclock);
    release dut.hit_count_r;
    ref_hits = 16'hFFFE;
    check("sat_forced", {16'd0, cif.hitCount}, 32'h0000FFFE);
    for (int n = 0; n < 3; n++) txn(1'b0, 16'h0405, 32'd0, 0, 1'b0);
    check("sat_final", {16'd0, cif.hitCount}, 32'h0000FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, with ports named as follows.
- globalclock  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
REQ-002 The CPU-side ports SHALL be:
- cpuReq  in  1  request strobe; sampled only in IDLE.
- cpuWrEn  in  1  1 = write, 0 = read.
- cpuAddr  in  16  word address; [15:10] = tag, [9:0] = index.
- cpuWrData  in  32  write data.
- cpuReady  out  1  high only in IDLE.
- cpuDone  out  1  one-cycle completion pulse.
- cpuRdData  out  32  read result; valid while cpuDone = 1, held until the next cpuDone.
REQ-003 The valid-bit store ports SHALL be:
- vAddress  out  10  line index.
- vWrEn  out  1  valid-bit write enable.
- vInValidity  out  1  valid-bit write value.
- vIsValid  in  1  combinational valid bit of line vAddress.
REQ-004 The RAM-side ports SHALL be:
- ramReq  out  1  request, held until ack.
- ramWrEn  out  1  1 = write.
- ramAddr  out  16  word address.
- ramWrData  out  32  write data.
- ramRdData  in  32  read data, valid with ramAck.
- ramAck  in  1  one-cycle completion.
REQ-005 The statistics ports SHALL be:
- hitCount  out  16  saturating count of hits.
- missCount  out  16  saturating count of read misses.

Function
REQ-006 The block SHALL be a direct-mapped cache of 1024 one-word lines, with an internal 1024x6 tag array and an internal 1024x32 data array; valid bits are held externally.
REQ-007 The FSM SHALL have four states: IDLE, LOOKUP, REFILL and WTHRU.
REQ-008 In IDLE, when cpuReq = 1, the block SHALL latch cpuAddr, cpuWrEn and cpuWrData and go to LOOKUP; cpuReq in any other state SHALL be ignored.
REQ-009 vAddress SHALL always equal the latched index.
REQ-010 In LOOKUP, hit SHALL be vIsValid AND (tagArray[index] == latched tag).
REQ-011 In LOOKUP on a read hit, the block SHALL set cpuRdData = dataArray[index], pulse cpuDone, increment hitCount and return to IDLE, for a total latency of 2 cycles from cpuReq.
REQ-012 In LOOKUP on a read miss, the block SHALL increment missCount and go to REFILL with ramReq = 1, ramWrEn = 0 and ramAddr = latched address.
REQ-013 In LOOKUP on a write, the block SHALL go to WTHRU with ramReq = 1, ramWrEn = 1, ramAddr = latched address and ramWrData = latched data.
REQ-014 A write hit SHALL also update dataArray[index] in the LOOKUP cycle and increment hitCount.
REQ-015 A write miss SHALL NOT allocate a line and SHALL NOT touch the valid bit, tag or data.
REQ-016 In REFILL, the block SHALL hold ramReq until ramAck; on the ramAck cycle it SHALL write dataArray[index] = ramRdData and tagArray[index] = tag, drive vWrEn = 1 and vInValidity = 1 for exactly that cycle, set cpuRdData = ramRdData, pulse cpuDone and return to IDLE.
REQ-017 In WTHRU, on ramAck the block SHALL pulse cpuDone and return to IDLE.
REQ-018 ramReq SHALL deassert on the edge following ramAck.
REQ-019 ramAck arriving in IDLE or LOOKUP SHALL be ignored.
REQ-020 vWrEn SHALL be 0 in every cycle except the REFILL ack cycle.
REQ-021 hitCount and missCount SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-022 A request SHALL be accepted in IDLE on the cycle immediately after cpuDone, so back-to-back requests are supported.

Reset
REQ-023 While reset = 1, the block SHALL force state = IDLE, cpuDone = 0, cpuRdData = 0, ramReq = 0, ramWrEn = 0, ramAddr = 0, ramWrData = 0, vWrEn = 0, hitCount = 0 and missCount = 0; cpuReady SHALL be 1 after reset.
REQ-024 Tag and data arrays SHALL NOT be reset; line validity is cleared by the external valid store, which shares the reset.
REQ-025 Reset asserted mid-REFILL or mid-WTHRU SHALL abandon the transaction: no cpuDone, ramReq = 0 on the next edge, and no valid-bit write.

Verification
REQ-026 Read 16'h0405 after reset -> miss; ramReq with ramAddr 16'h0405; ramAck with ramRdData 32'hDEADBEEF -> vWrEn = 1 on vAddress 10'h005, cpuDone with cpuRdData 32'hDEADBEEF; missCount = 1.
REQ-027 Re-read 16'h0405 -> cpuDone 2 cycles after cpuReq with data 32'hDEADBEEF, no ramReq, hitCount = 1.
REQ-028 Read 16'h0805 (same index, tag 2) -> miss and refill; a following read of 16'h0405 -> miss again.
REQ-029 Write 32'h12345678 to a cached address, then read it -> RAM write issued and the subsequent read hits with 32'h12345678; write to an uncached address -> RAM write only, next read misses.
REQ-030 Assert reset 2 cycles into REFILL, then assert ramAck -> no cpuDone, ramReq = 0, vWrEn never 1, counters = 0.
REQ-031 Force hitCount to 16'hFFFE, then perform 3 hits -> hitCount = 16'hFFFF.
